// File: rtl/pipe_skid_buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_skid_buffer_pkg: stage payload widths and bubble encoding        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package pipe_skid_buffer_pkg;

  localparam logic [15:0] NOP_INSTR   = 16'h0000;
  localparam int          IF_ID_W     = 32;
  localparam int          ID_EX_W     = 84;
  localparam int          EX_MEM_W    = 73;
  localparam int          MEM_WB_W    = 71;
  localparam int          FLUSH_CNT_W = 8;

endpackage
`default_nettype wire

// File: rtl/pipe_skid_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_skid_buffer_if: valid/ready handshake bundle at a stage boundary |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface pipe_skid_buffer_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] buffer_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] buffer_out;

  modport master (
    output in_valid, buffer_in, out_ready,
    input  in_ready, out_valid, buffer_out
  );

  modport slave (
    input  in_valid, buffer_in, out_ready,
    output in_ready, out_valid, buffer_out
  );
endinterface
`default_nettype wire

// File: rtl/pipe_skid_buffer_ring_ptr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_skid_buffer_ring_ptr: modulo-DEPTH pointer, inc + sync clear     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module pipe_skid_buffer_ring_ptr #(
  parameter  int DEPTH = 2,
  localparam int c_PW  = $clog2(DEPTH)
) (
  input  wire logic            clock,
  input  wire logic            reset,
  input  wire logic            clear,
  input  wire logic            inc,
  output logic      [c_PW-1:0] ptr
);
  localparam logic [c_PW-1:0] c_LAST = c_PW'(DEPTH - 1);

  logic [c_PW-1:0] r_ptr;

  // Explicit wrap so non-power-of-two depths stay in range.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ptr <= '0;
    end else if (clear) begin
      r_ptr <= '0;
    end else if (inc) begin
      r_ptr <= (r_ptr == c_LAST) ? '0 : r_ptr + c_PW'(1);
    end
  end

  assign ptr = r_ptr;
endmodule
`default_nettype wire

// File: rtl/pipe_skid_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_skid_buffer: DEPTH-entry elastic stage register with flush/hold  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module pipe_skid_buffer
  import pipe_skid_buffer_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter int               DEPTH  = 2,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}}
) (
  input  wire logic                           clock,
  input  wire logic                           reset,
  input  wire logic                           flush,
  input  wire logic                           hold,
  pipe_skid_buffer_if.slave                   bus,
  output logic      [$clog2(DEPTH+1)-1:0]     occupancy,
  output logic      [FLUSH_CNT_W-1:0]         flush_count
);
  localparam int              c_PW   = $clog2(DEPTH);
  localparam int              c_CW   = $clog2(DEPTH + 1);
  localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

  logic [WIDTH-1:0]       r_mem [DEPTH];
  logic [c_CW-1:0]        r_count;
  logic [FLUSH_CNT_W-1:0] r_flush_count;
  logic [c_PW-1:0]        w_head;
  logic [c_PW-1:0]        w_tail;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_push;
  logic                   w_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_FULL);

  // Ready depends on registered state only, never on out_ready.
  assign bus.in_ready   = !w_full && !hold && !flush && reset;
  assign bus.out_valid  = !w_empty && !flush;
  assign bus.buffer_out = w_empty ? BUBBLE : r_mem[w_head];

  assign w_push = bus.in_valid && bus.in_ready;
  assign w_pop  = bus.out_valid && bus.out_ready && !hold;

  pipe_skid_buffer_ring_ptr #(.DEPTH(DEPTH)) u_head (
    .clock (clock),
    .reset (reset),
    .clear (flush),
    .inc   (w_pop),
    .ptr   (w_head)
  );

  pipe_skid_buffer_ring_ptr #(.DEPTH(DEPTH)) u_tail (
    .clock (clock),
    .reset (reset),
    .clear (flush),
    .inc   (w_push),
    .ptr   (w_tail)
  );

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[w_tail] <= bus.buffer_in;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else if (w_push && !w_pop) begin
      r_count <= r_count + c_CW'(1);
    end else if (w_pop && !w_push) begin
      r_count <= r_count - c_CW'(1);
    end
  end

  // Only flushes that actually discard something are counted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_flush_count <= '0;
    end else if (flush && !w_empty && (r_flush_count != '1)) begin
      r_flush_count <= r_flush_count + FLUSH_CNT_W'(1);
    end
  end

  assign occupancy   = r_count;
  assign flush_count = r_flush_count;

  a_no_push_full: assert property (@(posedge clock) disable iff (!reset) !(w_push && w_full));
  a_no_pop_empty: assert property (@(posedge clock) disable iff (!reset) !(w_pop && w_empty));
  a_count_range:  assert property (@(posedge clock) disable iff (!reset) r_count <= c_FULL);
endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_skid_buffer: scoreboard bench, DEPTH=2 and DEPTH=3 instances  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_pipe_skid_buffer;
  import pipe_skid_buffer_pkg::*;

  localparam logic [31:0] c_BUB_A = 32'h0000_0013;
  localparam logic [31:0] c_BUB_B = 32'(NOP_INSTR);

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       flush_a = 1'b0, hold_a = 1'b0;
  logic       flush_b = 1'b0, hold_b = 1'b0;
  logic [1:0] occ_a, occ_b;
  logic [7:0] fc_a, fc_b;

  int          total = 0;
  int          bad   = 0;
  int          exp_fc_a = 0;
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];

  pipe_skid_buffer_if #(.WIDTH(IF_ID_W)) bus_a ();
  pipe_skid_buffer_if #(.WIDTH(IF_ID_W)) bus_b ();

  pipe_skid_buffer #(.WIDTH(IF_ID_W), .DEPTH(2), .BUBBLE(c_BUB_A)) dut_a (
    .clock (clock), .reset (reset), .flush (flush_a), .hold (hold_a),
    .bus (bus_a.slave), .occupancy (occ_a), .flush_count (fc_a)
  );

  pipe_skid_buffer #(.WIDTH(IF_ID_W), .DEPTH(3), .BUBBLE(c_BUB_B)) dut_b (
    .clock (clock), .reset (reset), .flush (flush_b), .hold (hold_b),
    .bus (bus_b.slave), .occupancy (occ_b), .flush_count (fc_b)
  );

  always #5 clock = ~clock;

  // One clock of DUT A: drive at edge+1, compare against the queue model, advance.
  task automatic cycle_a(input logic iv, input logic [31:0] d, input logic ordy,
                         input logic hld, input logic fl);
    logic        exp_rdy, exp_ov;
    logic [31:0] exp_out;
    bus_a.in_valid = iv; bus_a.buffer_in = d; bus_a.out_ready = ordy;
    hold_a = hld; flush_a = fl;
    #1;
    exp_rdy = (q_a.size() < 2) && !hld && !fl;
    exp_ov  = (q_a.size() != 0) && !fl;
    exp_out = (q_a.size() != 0) ? q_a[0] : c_BUB_A;
    total++;
    if (bus_a.in_ready !== exp_rdy) begin
      bad++; $display("FAIL a_in_ready t=%0t got=%b exp=%b", $time, bus_a.in_ready, exp_rdy);
    end
    total++;
    if (bus_a.out_valid !== exp_ov) begin
      bad++; $display("FAIL a_out_valid t=%0t got=%b exp=%b", $time, bus_a.out_valid, exp_ov);
    end
    total++;
    if (bus_a.buffer_out !== exp_out) begin
      bad++; $display("FAIL a_buffer_out t=%0t got=%h exp=%h", $time, bus_a.buffer_out, exp_out);
    end
    total++;
    if (occ_a !== 2'(q_a.size())) begin
      bad++; $display("FAIL a_occupancy t=%0t got=%0d exp=%0d", $time, occ_a, q_a.size());
    end
    if (fl) begin
      if (q_a.size() != 0 && exp_fc_a < 255) exp_fc_a++;
      q_a.delete();
    end else begin
      if (exp_ov && ordy && !hld) void'(q_a.pop_front());
      if (iv && exp_rdy) q_a.push_back(d);
    end
    @(posedge clock); #1;
    total++;
    if (fc_a !== 8'(exp_fc_a)) begin
      bad++; $display("FAIL a_flush_count t=%0t got=%0d exp=%0d", $time, fc_a, exp_fc_a);
    end
  endtask

  task automatic cycle_b(input logic iv, input logic [31:0] d, input logic ordy,
                         output logic accepted, output logic popped);
    logic        exp_rdy, exp_ov;
    logic [31:0] exp_out;
    bus_b.in_valid = iv; bus_b.buffer_in = d; bus_b.out_ready = ordy;
    #1;
    exp_rdy = (q_b.size() < 3);
    exp_ov  = (q_b.size() != 0);
    exp_out = exp_ov ? q_b[0] : c_BUB_B;
    total++;
    if (bus_b.in_ready !== exp_rdy || bus_b.out_valid !== exp_ov) begin
      bad++; $display("FAIL b_handshake t=%0t got rdy=%b vld=%b exp rdy=%b vld=%b",
                      $time, bus_b.in_ready, bus_b.out_valid, exp_rdy, exp_ov);
    end
    total++;
    if (bus_b.buffer_out !== exp_out || occ_b !== 2'(q_b.size())) begin
      bad++; $display("FAIL b_order t=%0t got=%h occ=%0d exp=%h occ=%0d",
                      $time, bus_b.buffer_out, occ_b, exp_out, q_b.size());
    end
    popped   = exp_ov && ordy;
    accepted = iv && exp_rdy;
    if (popped) void'(q_b.pop_front());
    if (accepted) q_b.push_back(d);
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    bus_a.in_valid = 1'b0; bus_a.buffer_in = '0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.buffer_in = '0; bus_b.out_ready = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    total++;
    if (bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b0 || occ_a !== 2'd0) begin
      bad++; $display("FAIL reset_held got vld=%b rdy=%b occ=%0d exp 0 0 0",
                      bus_a.out_valid, bus_a.in_ready, occ_a);
    end
    total++;
    if (bus_a.buffer_out !== c_BUB_A) begin
      bad++; $display("FAIL reset_bubble got=%h exp=%h", bus_a.buffer_out, c_BUB_A);
    end
    reset = 1'b1;
    #1;
    total++;
    if (bus_a.in_ready !== 1'b1 || bus_a.out_valid !== 1'b0 || occ_a !== 2'd0 || fc_a !== 8'd0) begin
      bad++; $display("FAIL reset_release got rdy=%b vld=%b occ=%0d fc=%0d exp 1 0 0 0",
                      bus_a.in_ready, bus_a.out_valid, occ_a, fc_a);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_streaming();
    cycle_a(1'b1, 32'h1111_1111, 1'b1, 1'b0, 1'b0);
    cycle_a(1'b1, 32'h2222_2222, 1'b1, 1'b0, 1'b0);
    cycle_a(1'b1, 32'h3333_3333, 1'b1, 1'b0, 1'b0);
    total++;
    if (occ_a !== 2'd1 || bus_a.buffer_out !== 32'h3333_3333) begin
      bad++; $display("FAIL stream_tail got occ=%0d out=%h exp occ=1 out=33333333", occ_a, bus_a.buffer_out);
    end
    cycle_a(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle_a(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    cycle_a(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    cycle_a(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    total++;
    if (occ_a !== 2'd2 || bus_a.in_ready !== 1'b0) begin
      bad++; $display("FAIL full_state got occ=%0d rdy=%b exp occ=2 rdy=0", occ_a, bus_a.in_ready);
    end
    cycle_a(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
    cycle_a(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
    cycle_a(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle_a(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_hold();
    cycle_a(1'b1, 32'h4444_4444, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle_a(1'b1, 32'h5555_5555, 1'b1, 1'b1, 1'b0);
      total++;
      if (bus_a.buffer_out !== 32'h4444_4444 || occ_a !== 2'd1 || bus_a.in_ready !== 1'b0) begin
        bad++; $display("FAIL hold_frozen got out=%h occ=%0d rdy=%b exp 44444444 1 0",
                        bus_a.buffer_out, occ_a, bus_a.in_ready);
      end
    end
    cycle_a(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle_a(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    cycle_a(1'b1, 32'h6666_6666, 1'b0, 1'b0, 1'b0);
    cycle_a(1'b1, 32'h7777_7777, 1'b0, 1'b0, 1'b0);
    cycle_a(1'b1, 32'h8888_8888, 1'b0, 1'b1, 1'b1);
    total++;
    if (occ_a !== 2'd0 || bus_a.buffer_out !== c_BUB_A || fc_a !== 8'd1) begin
      bad++; $display("FAIL flush_discard got occ=%0d out=%h fc=%0d exp 0 %h 1",
                      occ_a, bus_a.buffer_out, fc_a, c_BUB_A);
    end
    cycle_a(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    total++;
    if (fc_a !== 8'd1) begin
      bad++; $display("FAIL flush_empty got fc=%0d exp 1", fc_a);
    end
    cycle_a(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    cycle_a(1'b1, 32'h9999_9999, 1'b0, 1'b0, 1'b0);
    cycle_a(1'b1, 32'hAAAA_AAAA, 1'b0, 1'b0, 1'b0);
    bus_a.in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    total++;
    if (bus_a.out_valid !== 1'b0 || occ_a !== 2'd0 || bus_a.buffer_out !== c_BUB_A || fc_a !== 8'd0) begin
      bad++; $display("FAIL async_reset got vld=%b occ=%0d out=%h fc=%0d exp 0 0 %h 0",
                      bus_a.out_valid, occ_a, bus_a.buffer_out, fc_a, c_BUB_A);
    end
    q_a.delete();
    exp_fc_a = 0;
    #1 reset = 1'b1;
    @(posedge clock); #1;
    cycle_a(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_wrap_depth3();
    int   sent = 0;
    int   recv = 0;
    int   cyc  = 0;
    logic acc, pop;
    while ((sent < 10 || q_b.size() != 0) && cyc < 60) begin
      cycle_b(sent < 10, 32'hB000_0000 + 32'(sent), (cyc >= 4) && (cyc % 3 != 0), acc, pop);
      if (acc) sent++;
      if (pop) recv++;
      cyc++;
    end
    total++;
    if (recv != 10 || cyc >= 60) begin
      bad++; $display("FAIL wrap_count got recv=%0d cycles=%0d exp recv=10 within 60", recv, cyc);
    end
    cycle_b(1'b0, 32'h0, 1'b1, acc, pop);
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_hold();
    test_flush();
    test_async_reset();
    test_wrap_depth3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
    $fatal(1);
  end
endmodule
`default_nettype wire

// File: doc/pipe_skid_buffer.md
Name: pipe_skid_buffer

Overview:
- Parametrised successor to the fixed-width stage buffer (flush/hold register) used between pipeline stages.
- Adds a valid/ready handshake and a DEPTH-entry elastic store, so a downstream stall does not need a same-cycle global hold.
- One instance sits at each stage boundary: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Carries a bubble value for empty slots, an occupancy count and a saturating flush counter for the hazard unit.

Parameters:
- WIDTH, 32, payload bits per entry (e.g. 32 for IF/ID, 84 for ID/EX); must be at least 1.
- DEPTH, 2, number of storage entries; must be at least 2 (2 = classic skid).
- BUBBLE, {WIDTH{1'b0}}, value driven on buffer_out while the buffer is empty (a NOP encoding).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; 0 clears all state.
- flush  in  1  synchronous discard of all entries; sourced from branch control.
- hold  in  1  freezes the buffer; sourced from the hazard unit.
- in_valid  in  1  upstream stage presents buffer_in.
- in_ready  out  1  buffer accepts this cycle.
- buffer_in  in  WIDTH  payload from upstream.
- out_valid  out  1  buffer_out holds a real entry.
- out_ready  in  1  downstream consumes this cycle.
- buffer_out  out  WIDTH  head entry, or BUBBLE when empty.
- occupancy  out  $clog2(DEPTH+1)  number of stored entries.
- flush_count  out  8  flushes that discarded at least one entry; saturates at 255.

Behaviour:
- Storage and pointers:
  - Circular array mem[DEPTH], with head and tail pointers and a count.
  - Pointers wrap from DEPTH-1 to 0. DEPTH does not need to be a power of 2.
- Reset (reset=0, asynchronous):
  - head=0, tail=0, count=0, flush_count=0.
  - Outputs during reset: out_valid=0, in_ready=0, buffer_out=BUBBLE, occupancy=0.
  - Reset takes effect immediately, including mid-transfer. Contents of mem need not be cleared.
- Ready and valid:
  - in_ready = (count<DEPTH) & ~hold & ~flush & reset.
  - in_ready is registered-state based only: there is no combinational path from out_ready to in_ready.
  - out_valid = (count!=0) & ~flush.
  - buffer_out = mem[head] when count!=0, otherwise BUBBLE. It is combinational from registered state only.
- Transfers:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready & ~hold.
  - Push and pop in the same cycle: count is unchanged and both pointers advance.
  - Latency: an entry pushed in cycle N is visible on buffer_out in cycle N+1 when the buffer was empty.
  - Throughput: 1 entry per cycle when out_ready is held high.
- Full:
  - When count==DEPTH, in_ready=0 even if out_ready=1 in that cycle.
  - Full throughput therefore requires DEPTH≥2; this is the reason for the parameter minimum.
- Hold:
  - No push and no pop; state is frozen.
  - out_valid is still driven, so downstream may observe the head entry but cannot consume it.
- Flush (priority over hold, push and pop):
  - At the next edge: count=0 and head=tail.
  - The beat offered on in_valid in the flush cycle is dropped.
  - flush_count increments, saturating at 255, only if count!=0 at the edge.
  - Flush and reset together: reset wins.
- occupancy equals count at all times.
- Simulation assertions:
  - No push when full.
  - No pop when empty.
  - count ≤ DEPTH.

Decomposition:
- Shared package cpu_pkg, holding:
  - Bubble/NOP constant NOP_INSTR = 16'h0000.
  - Stage payload width constants IF_ID_W=32, ID_EX_W=84, EX_MEM_W, MEM_WB_W.
- The hazard unit and cpu instances use these constants as WIDTH and BUBBLE.
- One natural sub-module: ring_ptr. It is a parametrised modulo-DEPTH pointer register with increment enable and synchronous clear, instantiated twice (head and tail).

Test Plan:
- Reset and empty: drive reset=0, then release. Expect out_valid=0, buffer_out=BUBBLE, in_ready=1, occupancy=0.
- Streaming: WIDTH=32, DEPTH=2, out_ready=1, push 0x11111111, 0x22222222, 0x33333333 on consecutive cycles. Expect each on buffer_out exactly one cycle later, with occupancy staying at 1.
- Backpressure and full: out_ready=0, push 3 beats. After 2 pushes, expect occupancy=2 and in_ready=0, with the third beat held upstream. Then set out_ready=1 and expect the order 0xA, 0xB, then 0xC accepted.
- Hold: with occupancy=1, assert hold for 3 cycles while in_valid=1 and out_ready=1. Expect no count or pointer change, buffer_out stable, and in_ready=0.
- Flush: with occupancy=2, assert flush and hold together while in_valid=1. Expect occupancy=0 and buffer_out=BUBBLE next cycle, flush_count 0→1, and the offered beat dropped. A second flush while empty leaves flush_count=1.
- Asynchronous reset mid-stream: with occupancy=2, pulse reset=0 between clock edges. Expect out_valid=0 and occupancy=0 immediately, before the next edge. Also run DEPTH=3 wrap-around with 10 beats and check FIFO order.
